// File: rtl/control_unit_if.sv
// Handshake bundle between the accumulator CPU datapath and its control sequencer.
// The datapath side drives enable/opcode/zero; the sequencer side returns the strobes.
interface control_unit_if #(
   parameter int OPW = 3
);
   logic           ena;
   logic [OPW-1:0] opcode;
   logic           zero;
   logic           sel;
   logic           rd;
   logic           ldir;
   logic           inc_pc;
   logic           ld_pc;
   logic           ld_ac;
   logic           wr;
   logic           data_e;
   logic           halt;

   modport master (
      output ena, opcode, zero,
      input  sel, rd, ldir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
   );

   modport slave (
      input  ena, opcode, zero,
      output sel, rd, ldir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
   );
endinterface

// File: rtl/control_unit.sv
// Eight-state fetch/decode/execute sequencer for the 16-bit accumulator CPU,
// with a sticky HALTED state and an enable input that stalls the sequence.
module control_unit #(
   parameter int OPW = 3
) (
   input  logic          clk,
   input  logic          rst,
   control_unit_if.slave bus
);
   localparam logic [OPW-1:0] OP_HLT = OPW'(3'b000);
   localparam logic [OPW-1:0] OP_ADD = OPW'(3'b001);
   localparam logic [OPW-1:0] OP_AND = OPW'(3'b010);
   localparam logic [OPW-1:0] OP_XOR = OPW'(3'b011);
   localparam logic [OPW-1:0] OP_LDA = OPW'(3'b100);
   localparam logic [OPW-1:0] OP_STO = OPW'(3'b101);
   localparam logic [OPW-1:0] OP_SKZ = OPW'(3'b110);
   localparam logic [OPW-1:0] OP_JMP = OPW'(3'b111);

   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8
   } state_t;

   state_t state_r;
   state_t state_nxt_s;
   logic   ena_r;

   logic sel_s, rd_s, ldir_s, inc_pc_s, ld_pc_s, ld_ac_s, wr_s, data_e_s, halt_s;

   function automatic logic is_aluop(input logic [OPW-1:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

   // State register; ena_r remembers whether the last edge advanced so stall cycles emit no strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= INST_ADDR;
         ena_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ena_r   <= bus.ena;
      end
   end

   // Next-state logic; unknown encodings recover to INST_ADDR even while stalled.
   always_comb begin
      state_nxt_s = state_r;
      if (state_r > HALTED) begin
         state_nxt_s = INST_ADDR;
      end else if (!bus.ena) begin
         state_nxt_s = state_r;
      end else begin
         case (state_r)
            INST_ADDR:  state_nxt_s = INST_FETCH;
            INST_FETCH: state_nxt_s = INST_LOAD;
            INST_LOAD:  state_nxt_s = IDLE;
            IDLE:       state_nxt_s = OP_ADDR;
            OP_ADDR: begin
               if (bus.opcode == OP_HLT) begin
                  state_nxt_s = HALTED;
               end else begin
                  state_nxt_s = OP_FETCH;
               end
            end
            OP_FETCH:   state_nxt_s = ALU_OP;
            ALU_OP:     state_nxt_s = STORE;
            STORE:      state_nxt_s = INST_ADDR;
            HALTED:     state_nxt_s = HALTED;
            default:    state_nxt_s = INST_ADDR;
         endcase
      end
   end

   // Moore decode of registered state, qualified by opcode and zero where the instruction needs it.
   always_comb begin
      sel_s    = 1'b0;
      rd_s     = 1'b0;
      ldir_s   = 1'b0;
      inc_pc_s = 1'b0;
      ld_pc_s  = 1'b0;
      ld_ac_s  = 1'b0;
      wr_s     = 1'b0;
      data_e_s = 1'b0;
      halt_s   = 1'b0;
      case (state_r)
         INST_ADDR: begin
            sel_s = 1'b1;
         end
         INST_FETCH: begin
            sel_s = 1'b1;
            rd_s  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            sel_s  = 1'b1;
            rd_s   = 1'b1;
            ldir_s = 1'b1;
         end
         OP_ADDR: begin
            inc_pc_s = (bus.opcode != OP_HLT);
         end
         OP_FETCH: begin
            rd_s = is_aluop(bus.opcode);
         end
         ALU_OP: begin
            rd_s     = is_aluop(bus.opcode);
            inc_pc_s = (bus.opcode == OP_SKZ) && bus.zero;
            ld_pc_s  = (bus.opcode == OP_JMP);
            data_e_s = (bus.opcode == OP_STO);
         end
         STORE: begin
            rd_s     = is_aluop(bus.opcode);
            inc_pc_s = (bus.opcode == OP_JMP);
            ld_pc_s  = (bus.opcode == OP_JMP);
            ld_ac_s  = is_aluop(bus.opcode);
            wr_s     = (bus.opcode == OP_STO);
            data_e_s = (bus.opcode == OP_STO);
         end
         HALTED: begin
            sel_s  = 1'b1;
            halt_s = 1'b1;
         end
         default: begin
            sel_s = 1'b1;
         end
      endcase
   end

   assign bus.sel    = sel_s;
   assign bus.halt   = halt_s;
   assign bus.rd     = rd_s     & ena_r;
   assign bus.ldir   = ldir_s   & ena_r;
   assign bus.inc_pc = inc_pc_s & ena_r;
   assign bus.ld_pc  = ld_pc_s  & ena_r;
   assign bus.ld_ac  = ld_ac_s  & ena_r;
   assign bus.wr     = wr_s     & ena_r;
   assign bus.data_e = data_e_s & ena_r;
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model checked every
// cycle, plus hand-computed per-signal cycle patterns for each instruction class.
module tb_control_unit;
   localparam int B_SEL  = 8;
   localparam int B_RD   = 7;
   localparam int B_LDIR = 6;
   localparam int B_INC  = 5;
   localparam int B_LDPC = 4;
   localparam int B_LDAC = 3;
   localparam int B_WR   = 2;
   localparam int B_DE   = 1;
   localparam int B_HLT  = 0;

   logic clk;
   logic rst;

   control_unit_if #(.OPW(3)) bus ();

   control_unit #(.OPW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         m_phase = 0;
   bit         m_halt = 1'b0;
   bit         m_en = 1'b0;
   bit         m_valid = 1'b0;
   logic [8:0] tr [0:15];
   logic [8:0] last_v;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction-level model: count enabled steps within the 8-step instruction, latch halt.
   always @(posedge clk) begin
      if (rst === 1'b0) begin
         m_phase <= 0;
         m_halt  <= 1'b0;
         m_en    <= 1'b0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m_en <= bus.ena;
         if (bus.ena && !m_halt) begin
            if (m_phase == 4 && bus.opcode == 3'b000) m_halt <= 1'b1;
            else m_phase <= (m_phase + 1) % 8;
         end
      end
   end

   function automatic logic [8:0] model_out(input int ph, input bit hl, input bit en,
                                            input logic [2:0] op, input logic z);
      logic [8:0] v;
      logic       alu;
      v   = 9'd0;
      alu = (op >= 3'b001) && (op <= 3'b100);
      if (hl) begin
         v = 9'b100000001;
      end else begin
         v[B_SEL] = (ph < 4);
         if (en) begin
            v[B_RD]   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
            v[B_LDIR] = (ph == 2 || ph == 3);
            v[B_INC]  = (ph == 4 && op != 3'b000) || (ph == 6 && op == 3'b110 && z)
                        || (ph == 7 && op == 3'b111);
            v[B_LDPC] = (op == 3'b111) && (ph >= 6);
            v[B_LDAC] = (ph == 7) && alu;
            v[B_WR]   = (ph == 7) && (op == 3'b101);
            v[B_DE]   = (op == 3'b101) && (ph >= 6);
         end
      end
      return v;
   endfunction

   function automatic logic [8:0] cur();
      return {bus.sel, bus.rd, bus.ldir, bus.inc_pc, bus.ld_pc, bus.ld_ac,
              bus.wr, bus.data_e, bus.halt};
   endfunction

   function automatic logic [15:0] pat(input int b, input int n);
      logic [15:0] p;
      p = 16'd0;
      for (int i = 0; i < n; i++) p[i] = tr[i][b];
      return p;
   endfunction

   function automatic logic [15:0] strobe_pat(input int n);
      logic [15:0] p;
      p = 16'd0;
      for (int i = 0; i < n; i++) p[i] = |tr[i][7:1];
      return p;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // One clock: set inputs after the edge, sample at the falling edge, compare with the model.
   task automatic tick(input logic r, input logic e, input logic [2:0] op, input logic z,
                       input int idx);
      logic [8:0] exp;
      @(posedge clk);
      #1;
      rst        = r;
      bus.ena    = e;
      bus.opcode = op;
      bus.zero   = z;
      @(negedge clk);
      last_v = cur();
      if (idx >= 0 && idx < 16) tr[idx] = last_v;
      if (m_valid) begin
         exp = model_out(m_phase, m_halt, m_en, bus.opcode, bus.zero);
         n_cmp++;
         if (last_v !== exp) begin
            n_bad++;
            $display("FAIL model at %0t: got %b, expected %b", $time, last_v, exp);
         end
      end
   endtask

   task automatic do_reset(input logic [2:0] op);
      tick(1'b0, 1'b1, op, 1'b0, -1);
      tick(1'b0, 1'b1, op, 1'b0, -1);
   endtask

   task automatic run(input logic [2:0] op, input logic z, input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b1, op, z, i);
   endtask

   initial begin
      rst        = 1'b0;
      bus.ena    = 1'b0;
      bus.opcode = 3'b000;
      bus.zero   = 1'b0;

      do_reset(3'b001);
      chk("reset_outputs", {7'd0, last_v}, 16'b100000000);

      // ADD: two back-to-back instructions
      run(3'b001, 1'b0, 16);
      chk("add_rd_0_7",  pat(B_RD, 8),   16'b11101110);
      chk("add_ldir",    pat(B_LDIR, 8), 16'b00001100);
      chk("add_inc_pc",  pat(B_INC, 8),  16'b00010000);
      chk("add_ld_ac",   pat(B_LDAC, 8), 16'b10000000);
      chk("add_sel",     pat(B_SEL, 8),  16'b00001111);
      chk("add_rd_8_15", {8'd0, tr[15][B_RD], tr[14][B_RD], tr[13][B_RD], tr[12][B_RD],
                          tr[11][B_RD], tr[10][B_RD], tr[9][B_RD], tr[8][B_RD]}, 16'b11101110);

      // reset in the middle of an instruction
      run(3'b001, 1'b0, 6);
      do_reset(3'b101);
      chk("mid_reset", {7'd0, last_v}, 16'b100000000);

      run(3'b101, 1'b0, 8);
      chk("sto_data_e", pat(B_DE, 8),   16'b11000000);
      chk("sto_wr",     pat(B_WR, 8),   16'b10000000);
      chk("sto_rd",     pat(B_RD, 8),   16'b00001110);
      chk("sto_ld_ac",  pat(B_LDAC, 8), 16'b00000000);

      do_reset(3'b110);
      run(3'b110, 1'b1, 8);
      chk("skz_z1_inc", pat(B_INC, 8), 16'b01010000);
      do_reset(3'b110);
      run(3'b110, 1'b0, 8);
      chk("skz_z0_inc", pat(B_INC, 8), 16'b00010000);

      do_reset(3'b111);
      run(3'b111, 1'b0, 8);
      chk("jmp_ld_pc", pat(B_LDPC, 8), 16'b11000000);
      chk("jmp_inc",   pat(B_INC, 8),  16'b10010000);
      chk("jmp_sel",   pat(B_SEL, 8),  16'b00001111);

      // ADD stalled while in ALU_OP: strobes vanish, ld_ac moves out by two
      do_reset(3'b001);
      for (int i = 0; i < 12; i++) tick(1'b1, (i == 6 || i == 7) ? 1'b0 : 1'b1, 3'b001, 1'b0, i);
      chk("add_stall_ld_ac", pat(B_LDAC, 12), 16'b001000000000);
      chk("add_stall_rd",    pat(B_RD, 12),   16'b101001101110);

      do_reset(3'b000);
      run(3'b000, 1'b0, 12);
      chk("hlt_halt",    pat(B_HLT, 12),  16'b111111100000);
      chk("hlt_strobes", strobe_pat(12),  16'b000000001110);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 3'b001, 1'b1, -1);
      chk("hlt_sticky",  {7'd0, last_v}, 16'b100000001);
      do_reset(3'b000);
      chk("hlt_cleared", {7'd0, last_v}, 16'b100000000);

      // HLT with ena low for four edges starting at cycle 3
      for (int i = 0; i < 12; i++) tick(1'b1, (i >= 3 && i <= 6) ? 1'b0 : 1'b1, 3'b000, 1'b0, i);
      chk("stall_halt",    pat(B_HLT, 12),  16'b111000000000);
      chk("stall_ldir",    pat(B_LDIR, 12), 16'b000000001100);
      chk("stall_strobes", strobe_pat(12),  16'b000000001110);
      chk("stall_sel",     pat(B_SEL, 12),  16'b111011111111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
